// File: rtl/tt_um_nasser_hadi_nrzi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tt_um_nasser_hadi_nrzi_rx
//  Description : Toggle-line (NRZI) framed receiver. The line is oversampled
//                and the bit phase re-aligns on every transition. Bits are
//                recovered by XOR of successive mid-bit samples. The block
//                hunts for a sync byte, reads a length byte, then delivers
//                that many payload bytes.
//  Ports       : clk, rst_n    - clock, asynchronous active-low reset
//                ena           - tile enable (ignored)
//                ui_in[0]      - NRZI line; ui_in[1] - rx_en
//                uo_out        - last delivered payload byte (holds)
//                uio_out[0]    - byte_valid pulse
//                uio_out[1]    - in_frame
//                uio_out[2]    - sync_hit pulse
//                uio_out[3]    - len_zero pulse
//                uio_oe        - constant 8'h0F
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_um_nasser_hadi_nrzi_rx #(
    parameter int         CLKS_PER_BIT = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int              PH_W    = $clog2(CLKS_PER_BIT);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(CLKS_PER_BIT / 2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Synchronizer, edge detect and phase tracking
    logic            s1_q, s2_q, s2d_q;
    logic            en_q;
    logic [PH_W-1:0] ph_q, ph_d;
    logic            prev_q, prev_d;
    logic            edge_w;
    logic            strobe_w;
    logic [7:0]      sr_shift_w;

    // Framing state
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] remaining_q, remaining_d;
    logic [7:0] uo_q, uo_d;
    logic       byte_valid_q, byte_valid_d;
    logic       sync_hit_q, sync_hit_d;
    logic       len_zero_q, len_zero_d;

    logic       unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:2]};

    assign edge_w = s2_q ^ s2d_q;
    // A transition landing on the mid-bit count re-aligns instead of sampling.
    assign strobe_w   = (ph_q == PH_MID) && !edge_w;
    assign sr_shift_w = {s2_q ^ prev_q, sr_q[7:1]};

    always_comb begin
        if (edge_w) begin
            ph_d = PH_W'(1);
        end else if (ph_q == PH_LAST) begin
            ph_d = '0;
        end else begin
            ph_d = ph_q + PH_W'(1);
        end
        // Line history keeps running even while disabled so that the first
        // bit after re-enable decodes against the true previous level.
        prev_d = strobe_w ? s2_q : prev_q;
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sr_d         = sr_q;
        remaining_d  = remaining_q;
        uo_d         = uo_q;
        byte_valid_d = 1'b0;
        sync_hit_d   = 1'b0;
        len_zero_d   = 1'b0;

        if (!en_q) begin
            // Abort has priority over any byte completing this cycle.
            state_d   = ST_HUNT;
            bit_cnt_d = 3'd0;
            sr_d      = 8'h00;
        end else if (strobe_w) begin
            sr_d = sr_shift_w;
            case (state_q)
                ST_HUNT: begin
                    if (sr_shift_w == SYNC_BYTE) begin
                        sync_hit_d = 1'b1;
                        bit_cnt_d  = 3'd0;
                        state_d    = ST_LEN;
                    end
                end
                ST_LEN: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        remaining_d = sr_shift_w;
                        bit_cnt_d   = 3'd0;
                        if (sr_shift_w == 8'h00) begin
                            len_zero_d = 1'b1;
                            state_d    = ST_HUNT;
                            sr_d       = 8'h00;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        uo_d         = sr_shift_w;
                        byte_valid_d = 1'b1;
                        remaining_d  = remaining_q - 8'd1;
                        bit_cnt_d    = 3'd0;
                        if (remaining_q == 8'd1) begin
                            state_d = ST_HUNT;
                            sr_d    = 8'h00;
                        end
                    end
                end
                default: begin
                    state_d   = ST_HUNT;
                    bit_cnt_d = 3'd0;
                    sr_d      = 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s2d_q        <= 1'b0;
            en_q         <= 1'b0;
            ph_q         <= '0;
            prev_q       <= 1'b0;
            state_q      <= ST_HUNT;
            bit_cnt_q    <= 3'd0;
            sr_q         <= 8'h00;
            remaining_q  <= 8'h00;
            uo_q         <= 8'h00;
            byte_valid_q <= 1'b0;
            sync_hit_q   <= 1'b0;
            len_zero_q   <= 1'b0;
        end else begin
            s1_q         <= ui_in[0];
            s2_q         <= s1_q;
            s2d_q        <= s2_q;
            en_q         <= ui_in[1];
            ph_q         <= ph_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sr_q         <= sr_d;
            remaining_q  <= remaining_d;
            uo_q         <= uo_d;
            byte_valid_q <= byte_valid_d;
            sync_hit_q   <= sync_hit_d;
            len_zero_q   <= len_zero_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = {4'b0000, len_zero_q, sync_hit_q,
                      (state_q == ST_LEN) || (state_q == ST_DATA), byte_valid_q};
    assign uio_oe  = 8'h0F;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_nasser_hadi_nrzi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tt_um_nasser_hadi_nrzi_rx
//  Description : Self-checking bench for the NRZI framed receiver. A T
//                flip-flop encoder drives the line; a table of frames plus
//                hand-written abort / drift / reset sequences are checked.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_nasser_hadi_nrzi_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line;
    logic       en;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    assign ui_in  = {6'b000000, en, line};
    assign uio_in = 8'h00;

    tt_um_nasser_hadi_nrzi_rx #(
        .CLKS_PER_BIT (8),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (1'b1),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Pulse monitor: counts strobes, captures delivered bytes, flags any
    // pulse lasting more than one clock.
    int         n_bv   = 0;
    int         n_sync = 0;
    int         n_lz   = 0;
    int         n_dbl  = 0;
    logic [7:0] prev_flags = 8'h00;
    logic [7:0] got[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_flags <= 8'h00;
        end else begin
            if (uio_out[0]) begin
                n_bv <= n_bv + 1;
                got.push_back(uo_out);
            end
            if (uio_out[2]) n_sync <= n_sync + 1;
            if (uio_out[3]) n_lz <= n_lz + 1;
            if ((uio_out & prev_flags & 8'h0D) != 8'h00) n_dbl <= n_dbl + 1;
            prev_flags <= uio_out;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int bit_idx  = 0;
    bit drift    = 1'b0;
    int b_bv, b_sync, b_lz, b_got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int cur_per();
        if (drift) return (bit_idx % 2 == 0) ? 7 : 9;
        return 8;
    endfunction

    // One bit period: a 1 toggles the line at bit start, a 0 holds it.
    task automatic send_bit(input logic b);
        int per;
        per = cur_per();
        @(negedge clk);
        if (b) line = ~line;
        repeat (per - 1) @(negedge clk);
        bit_idx++;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        line  = 1'b0;
        en    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);
    endtask

    task automatic snap();
        b_bv   = n_bv;
        b_sync = n_sync;
        b_lz   = n_lz;
        b_got  = got.size();
    endtask

    typedef struct packed {
        logic [7:0]      npre;
        logic [7:0]      pre;
        logic [7:0]      nb;
        logic [0:5][7:0] b;
        logic [7:0]      exp_sync;
        logic [7:0]      exp_lz;
        logic [7:0]      exp_bv;
        logic [7:0]      exp_uo;
        logic [7:0]      exp_first;
    } vec_t;

    vec_t tab[6];

    initial begin
        rst_n = 1'b0;
        line  = 1'b0;
        en    = 1'b0;

        //           npre pre   nb   bytes (first sent leftmost)                          sync lz bv uo   first
        tab[0] = '{8'd0, 8'h00, 8'd4, {8'hA5, 8'h02, 8'h3C, 8'hC3, 8'h00, 8'h00}, 8'd1, 8'd0, 8'd2, 8'hC3, 8'h3C};
        tab[1] = '{8'd0, 8'h00, 8'd2, {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'd1, 8'd1, 8'd0, 8'h00, 8'h00};
        tab[2] = '{8'd0, 8'h00, 8'd5, {8'hA5, 8'h00, 8'hA5, 8'h01, 8'h5A, 8'h00}, 8'd2, 8'd1, 8'd1, 8'h5A, 8'h5A};
        tab[3] = '{8'd2, 8'h03, 8'd3, {8'hA5, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00}, 8'd1, 8'd0, 8'd1, 8'hFF, 8'hFF};
        tab[4] = '{8'd0, 8'h00, 8'd5, {8'hA5, 8'h03, 8'h00, 8'h80, 8'h01, 8'h00}, 8'd1, 8'd0, 8'd3, 8'h01, 8'h00};
        tab[5] = '{8'd0, 8'h00, 8'd2, {8'h5A, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00}, 8'd0, 8'd0, 8'd0, 8'h00, 8'h00};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset uo_out", {24'h0, uo_out}, 32'h00);
        check("reset uio_out", {24'h0, uio_out}, 32'h00);
        check("uio_oe", {24'h0, uio_oe}, 32'h0F);

        // Table-driven frames
        for (int r = 0; r < 6; r++) begin
            do_reset();
            snap();
            idle(16);
            for (int k = 0; k < int'(tab[r].npre); k++) send_bit(tab[r].pre[k]);
            for (int k = 0; k < int'(tab[r].nb); k++) send_byte(tab[r].b[k]);
            idle(4);
            check($sformatf("row%0d sync_hit count", r), n_sync - b_sync, {24'h0, tab[r].exp_sync});
            check($sformatf("row%0d len_zero count", r), n_lz - b_lz, {24'h0, tab[r].exp_lz});
            check($sformatf("row%0d byte_valid count", r), n_bv - b_bv, {24'h0, tab[r].exp_bv});
            check($sformatf("row%0d uo_out", r), {24'h0, uo_out}, {24'h0, tab[r].exp_uo});
            check($sformatf("row%0d in_frame", r), {31'h0, uio_out[1]}, 32'h0);
            if (tab[r].exp_bv != 8'd0 && got.size() > b_got)
                check($sformatf("row%0d first byte", r), {24'h0, got[b_got]}, {24'h0, tab[r].exp_first});
        end

        // Abort mid-byte, then recover
        do_reset();
        snap();
        idle(16);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("abort in_frame before", {31'h0, uio_out[1]}, 32'h1);
        en = 1'b0;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        check("abort byte_valid count", n_bv - b_bv, 32'd1);
        check("abort in_frame", {31'h0, uio_out[1]}, 32'h0);
        check("abort uo_out holds", {24'h0, uo_out}, 32'h11);
        en = 1'b1;
        idle(8);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h22);
        idle(4);
        check("reenable uo_out", {24'h0, uo_out}, 32'h22);
        check("reenable byte_valid count", n_bv - b_bv, 32'd2);

        // Bit periods alternating 7 / 9 clocks
        do_reset();
        snap();
        drift   = 1'b1;
        bit_idx = 0;
        idle(16);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h96);
        idle(4);
        drift = 1'b0;
        check("drift uo_out", {24'h0, uo_out}, 32'h96);
        check("drift byte_valid count", n_bv - b_bv, 32'd1);

        // Asynchronous reset during DATA
        do_reset();
        snap();
        idle(16);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h44);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        check("pre-reset uo_out", {24'h0, uo_out}, 32'h44);
        check("pre-reset in_frame", {31'h0, uio_out[1]}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset uo_out", {24'h0, uo_out}, 32'h00);
        check("async reset uio_out", {24'h0, uio_out}, 32'h00);
        line = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle(16);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h81);
        idle(4);
        check("post-reset uo_out", {24'h0, uo_out}, 32'h81);

        check("pulse width one clock", n_dbl, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
